// File: rtl/subtractor_serial_8b.sv
// rtl/subtractor_serial_8b.sv - bit-serial subtractor, LSB first, with val/rdy request and response
module subtractor_serial_8b #(
  parameter int NBITS = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_val,
  output logic             req_rdy,
  input  logic [NBITS-1:0] in0,
  input  logic [NBITS-1:0] in1,
  input  logic             bin,
  output logic             resp_val,
  input  logic             resp_rdy,
  output logic [NBITS-1:0] diff,
  output logic             bout
);

  localparam int CW = (NBITS > 1) ? $clog2(NBITS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [NBITS-1:0] a_sr;
  logic [NBITS-1:0] b_sr;
  logic             borrow;
  logic [CW-1:0]    cnt;

  logic             a_bit;
  logic             b_bit;
  logic             d_bit;
  logic             borrow_next;
  logic             last_bit;
  logic             req_fire;
  logic             resp_fire;

  // Full-subtractor slice on the current LSBs of the operand shift registers
  always_comb begin
    a_bit       = a_sr[0];
    b_bit       = b_sr[0];
    d_bit       = a_bit ^ b_bit ^ borrow;
    borrow_next = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & borrow);
    last_bit    = (cnt == CW'(NBITS - 1));
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake outputs; ready/valid depend on state only
  always_comb begin
    state_next = state;
    req_rdy    = 1'b0;
    resp_val   = 1'b0;
    req_fire   = 1'b0;
    resp_fire  = 1'b0;
    case (state)
      IDLE: begin
        req_rdy  = 1'b1;
        req_fire = req_val;
        if (req_val) begin
          state_next = CALC;
        end
      end
      CALC: begin
        if (last_bit) begin
          state_next = DONE;
        end
      end
      DONE: begin
        resp_val  = 1'b1;
        resp_fire = resp_rdy;
        if (resp_rdy) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath: load operands on accept, shift one bit per cycle while calculating
  always_ff @(posedge clk) begin
    if (reset) begin
      a_sr   <= '0;
      b_sr   <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
      diff   <= '0;
      bout   <= 1'b0;
    end else if (state == IDLE) begin
      if (req_fire) begin
        a_sr   <= in0;
        b_sr   <= in1;
        borrow <= bin;
        cnt    <= '0;
      end
    end else if (state == CALC) begin
      a_sr   <= {1'b0, a_sr[NBITS-1:1]};
      b_sr   <= {1'b0, b_sr[NBITS-1:1]};
      borrow <= borrow_next;
      diff   <= {d_bit, diff[NBITS-1:1]};
      cnt    <= cnt + CW'(1);
      if (last_bit) begin
        bout <= borrow_next;
      end
    end
  end

  // resp_fire is decoded for readability of the DONE exit; results simply hold
  logic unused_ok;
  assign unused_ok = resp_fire;

endmodule

// File: tb/tb_subtractor_serial_8b.sv
// tb/tb_subtractor_serial_8b.sv - self-checking bench for subtractor_serial_8b
module tb_subtractor_serial_8b;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_val;
  logic       req_rdy;
  logic [7:0] in0;
  logic [7:0] in1;
  logic       bin;
  logic       resp_val;
  logic       resp_rdy;
  logic [7:0] diff;
  logic       bout;

  int tests_run = 0;
  int fails = 0;

  subtractor_serial_8b #(.NBITS(8)) dut (
    .clk(clk),
    .reset(reset),
    .req_val(req_val),
    .req_rdy(req_rdy),
    .in0(in0),
    .in1(in1),
    .bin(bin),
    .resp_val(resp_val),
    .resp_rdy(resp_rdy),
    .diff(diff),
    .bout(bout)
  );

  always #5 clk = ~clk;

  // Golden result: plain 9-bit unsigned subtraction
  function automatic logic [8:0] golden(input logic [7:0] a, input logic [7:0] b, input logic bi);
    logic [8:0] r;
    r = {1'b0, a} - {1'b0, b} - {8'b0, bi};
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_req(input logic [7:0] a, input logic [7:0] b, input logic bi);
    int n;
    n = 0;
    while (!req_rdy && n < 30) begin
      tick();
      n++;
    end
    if (!req_rdy) begin
      tests_run++;
      fails++;
      $display("FAIL req_rdy_timeout: req_rdy=%0b required 1", req_rdy);
    end
    in0 = a;
    in1 = b;
    bin = bi;
    req_val = 1'b1;
    tick();
    req_val = 1'b0;
    in0 = $urandom;
    in1 = $urandom;
    bin = $urandom_range(0, 1);
  endtask

  task automatic wait_resp(output int lat);
    lat = -1;
    for (int n = 1; n <= 30; n++) begin
      tick();
      if (resp_val) begin
        lat = n;
        break;
      end
    end
    if (lat < 0) begin
      tests_run++;
      fails++;
      $display("FAIL resp_timeout: resp_val=%0b required 1 within 30 cycles", resp_val);
    end
  endtask

  task automatic handshake();
    resp_rdy = 1'b1;
    tick();
    resp_rdy = 1'b0;
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic bi,
                        input string name, input logic check_lat);
    int lat;
    logic [8:0] exp;
    exp = golden(a, b, bi);
    start_req(a, b, bi);
    wait_resp(lat);
    if (check_lat) begin
      tests_run++;
      if (lat !== 8) begin
        fails++;
        $display("FAIL %s_latency: got %0d cycles required 8", name, lat);
      end
    end
    tests_run++;
    if (diff !== exp[7:0]) begin
      fails++;
      $display("FAIL %s_diff: got %02h required %02h", name, diff, exp[7:0]);
    end
    tests_run++;
    if (bout !== exp[8]) begin
      fails++;
      $display("FAIL %s_bout: got %0b required %0b", name, bout, exp[8]);
    end
    handshake();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    tests_run++;
    if (req_rdy !== 1'b1) begin fails++; $display("FAIL reset_req_rdy: got %0b required 1", req_rdy); end
    tests_run++;
    if (resp_val !== 1'b0) begin fails++; $display("FAIL reset_resp_val: got %0b required 0", resp_val); end
    tests_run++;
    if (diff !== 8'h00) begin fails++; $display("FAIL reset_diff: got %02h required 00", diff); end
    tests_run++;
    if (bout !== 1'b0) begin fails++; $display("FAIL reset_bout: got %0b required 0", bout); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    logic [7:0] exp_d;
    int lat;
    exp_d = 8'h02;
    start_req(8'h05, 8'h03, 1'b0);
    wait_resp(lat);
    tests_run++;
    if (lat !== 8) begin fails++; $display("FAIL basic_latency: got %0d required 8", lat); end
    tests_run++;
    if (diff !== exp_d) begin fails++; $display("FAIL basic_diff: got %02h required %02h", diff, exp_d); end
    tests_run++;
    if (bout !== 1'b0) begin fails++; $display("FAIL basic_bout: got %0b required 0", bout); end
    handshake();
  endtask

  task automatic test_borrow_wrap();
    logic [7:0] ta [4] = '{8'h00, 8'h00, 8'h80, 8'hAA};
    logic [7:0] tb [4] = '{8'h01, 8'hFF, 8'h7F, 8'h55};
    logic       tc [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [7:0] ed [4] = '{8'hFF, 8'h00, 8'h00, 8'h55};
    logic       eb [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    int lat;
    for (int i = 0; i < 4; i++) begin
      start_req(ta[i], tb[i], tc[i]);
      wait_resp(lat);
      tests_run++;
      if (diff !== ed[i]) begin fails++; $display("FAIL wrap%0d_diff: got %02h required %02h", i, diff, ed[i]); end
      tests_run++;
      if (bout !== eb[i]) begin fails++; $display("FAIL wrap%0d_bout: got %0b required %0b", i, bout, eb[i]); end
      handshake();
    end
    run_op(8'h42, 8'h42, 1'b0, "equal", 1'b1);
  endtask

  task automatic test_backpressure();
    int lat;
    logic ok;
    start_req(8'h3C, 8'h0F, 1'b0);
    wait_resp(lat);
    in0 = 8'h11;
    in1 = 8'h22;
    bin = 1'b0;
    req_val = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (resp_val !== 1'b1 || diff !== 8'h2D || bout !== 1'b0 || req_rdy !== 1'b0) begin
        ok = 1'b0;
        $display("FAIL bp_hold_cycle%0d: resp_val=%0b diff=%02h bout=%0b req_rdy=%0b required 1/2d/0/0",
                 i, resp_val, diff, bout, req_rdy);
      end
    end
    tests_run++;
    if (!ok) fails++;
    resp_rdy = 1'b1;
    tick();
    req_val = 1'b0;
    resp_rdy = 1'b0;
    tests_run++;
    if (req_rdy !== 1'b1 || resp_val !== 1'b0) begin
      fails++;
      $display("FAIL bp_release: req_rdy=%0b resp_val=%0b required 1/0", req_rdy, resp_val);
    end
    run_op(8'h11, 8'h22, 1'b0, "bp_next", 1'b1);
  endtask

  task automatic test_reset_mid();
    logic seen;
    start_req(8'h77, 8'h12, 1'b1);
    tick();
    tick();
    reset = 1'b1;
    resp_rdy = 1'b1;
    tick();
    reset = 1'b0;
    resp_rdy = 1'b0;
    tests_run++;
    if (req_rdy !== 1'b1 || resp_val !== 1'b0 || diff !== 8'h00 || bout !== 1'b0) begin
      fails++;
      $display("FAIL midreset_state: req_rdy=%0b resp_val=%0b diff=%02h bout=%0b required 1/0/00/0",
               req_rdy, resp_val, diff, bout);
    end
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (resp_val) seen = 1'b1;
    end
    tests_run++;
    if (seen !== 1'b0) begin fails++; $display("FAIL midreset_no_resp: resp_val seen=%0b required 0", seen); end
    run_op(8'h10, 8'h01, 1'b0, "after_reset", 1'b1);
  endtask

  task automatic test_random();
    int unsigned seed;
    logic [7:0] a;
    logic [7:0] b;
    logic bi;
    logic [8:0] exp;
    logic checked;
    logic hs;
    int n;
    seed = 32'hC0FFEE;
    a = 8'($urandom(seed));
    for (int t = 0; t < 20; t++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      bi = 1'($urandom_range(0, 1));
      exp = golden(a, b, bi);
      start_req(a, b, bi);
      checked = 1'b0;
      hs = 1'b0;
      n = 0;
      while (!hs && n < 200) begin
        if (resp_val && !checked) begin
          checked = 1'b1;
          tests_run++;
          if ({bout, diff} !== exp) begin
            fails++;
            $display("FAIL rand%0d: %02h-%02h-%0b got {%0b,%02h} required {%0b,%02h}",
                     t, a, b, bi, bout, diff, exp[8], exp[7:0]);
          end
        end
        resp_rdy = 1'($urandom_range(0, 1));
        hs = resp_val && resp_rdy;
        tick();
        n++;
      end
      resp_rdy = 1'b0;
      if (!hs) begin
        tests_run++;
        fails++;
        $display("FAIL rand%0d_timeout: no response handshake in 200 cycles", t);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    req_val = 1'b0;
    resp_rdy = 1'b0;
    in0 = 8'h00;
    in1 = 8'h00;
    bin = 1'b0;
    test_reset();
    test_basic();
    test_borrow_wrap();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
